// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with one-entry skid buffer
// Fully registered ready/valid stage between fetch and decode, with flush and stall counter.
module if_id_skid_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [15:0]     stall_cnt
);

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_inst_q, main_inst_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            accept;
  logic            consume;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pc    = main_valid_q ? main_pc_q : '0;
  assign out_inst  = main_valid_q ? main_inst_q : NOP_INST;
  assign stall_cnt = stall_cnt_q;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    stall_cnt_d  = stall_cnt_q;

    if (main_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Skid is only ever occupied while main is, so an empty main implies an empty skid.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_pc_d    = in_pc;
        main_inst_d  = in_inst;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_pc_d   = in_pc;
        main_inst_d = in_inst;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_inst_d  = in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_inst_q  <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      stall_cnt_q  <= 16'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - self-checking bench for if_id_skid_reg
// Two-deep FIFO reference model checked every cycle, plus literal expectations.
module tb_if_id_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_skid_reg #(.XLEN(32), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the stage behaves as an ordered queue of at most two entries.
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  int          m_stall = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc.delete();
      m_inst.delete();
      m_stall = 0;
    end else begin
      automatic bit acc = in_valid && (m_pc.size() < 2);
      automatic bit con = (m_pc.size() > 0) && out_ready;
      if (m_pc.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        m_pc.delete();
        m_inst.delete();
      end else begin
        if (con) begin
          void'(m_pc.pop_front());
          void'(m_inst.pop_front());
        end
        if (acc) begin
          m_pc.push_back(in_pc);
          m_inst.push_back(in_inst);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_pc.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, m_pc.size() < 2});
    check("out_pc", out_pc, (m_pc.size() > 0) ? m_pc[0] : 32'd0);
    check("out_inst", out_inst, (m_inst.size() > 0) ? m_inst[0] : 32'h0000_0013);
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
  end

  task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = {pc[15:0], 16'h0093} ^ 32'h00A0_0000;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b1;

    // single pass
    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h00A0_0093; out_ready = 1'b1;
    @(negedge clk); #1;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_pc", out_pc, 32'h100);
    check("single_inst", out_inst, 32'h00A0_0093);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("single_drain", {31'd0, out_valid}, 32'd0);

    // full throughput
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
      check("thru_pc", out_pc, 32'h400 + 32'(4 * i));
      check("thru_ready", {31'd0, in_ready}, 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("thru_stall", {16'd0, stall_cnt}, 32'd0);

    // backpressure
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 1'b0, 1'b0);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 32'h108, 1'b0, 1'b0);
    check("bp_main_held", out_pc, 32'h100);
    check("bp_stall", {16'd0, stall_cnt}, 32'd2);
    cycle(1'b1, 32'h108, 1'b1, 1'b0);
    check("bp_second", out_pc, 32'h104);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    cycle(1'b1, 32'h108, 1'b1, 1'b0);
    check("bp_third", out_pc, 32'h108);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush with both entries full, and flush discarding a same-cycle accept
    cycle(1'b1, 32'h180, 1'b0, 1'b0);
    cycle(1'b1, 32'h184, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    check("fl_inst", out_inst, 32'h0000_0013);
    check("fl_pc", out_pc, 32'd0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_no_200", {31'd0, out_valid}, 32'd0);
    check("fl_stall", {16'd0, stall_cnt}, 32'd5);

    // stall counter saturation
    cycle(1'b1, 32'h500, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("sat_after_flush", {16'd0, stall_cnt}, 32'h0000_FFFF);

    // asynchronous reset with both entries full, then resume
    cycle(1'b1, 32'h540, 1'b0, 1'b0);
    cycle(1'b1, 32'h544, 1'b0, 1'b0);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_stall", {16'd0, stall_cnt}, 32'd0);
    check("arst_inst", out_inst, 32'h0000_0013);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    cycle(1'b1, 32'h600, 1'b1, 1'b0);
    check("resume_pc", out_pc, 32'h600);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
